// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared types and constants for the instruction-fetch stage.
//   InstAddrBus / InstBus : 32-bit address and instruction word types
//   INST_NOP              : instruction shown on inst_o when nothing is valid
//   fetch_entry_t         : one fetch-queue slot (PC tag, data, filled flag)
//   word_align()          : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    localparam InstBus INST_NOP = 32'h0000_0013;

    typedef struct packed {
        InstAddrBus pc;
        InstBus     inst;
        logic       filled;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, inst: INST_NOP, filled: 1'b0};

    function automatic InstAddrBus word_align(input InstAddrBus addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/grant/response bus.
//   req    : fetch request (master -> slave)
//   addr   : word-aligned fetch address, held while req=1 and gnt=0
//   gnt    : request accepted this cycle (slave -> master)
//   rvalid : read data valid, returned in request order
//   rdata  : instruction word
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic       req;
    InstAddrBus addr;
    logic       gnt;
    logic       rvalid;
    InstBus     rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/if_fetch_unit_chk.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_chk
// Protocol checks for the fetch stage's memory interface.
//   clk, rst   : clock, asynchronous active-high reset
//   i_rvalid   : memory response strobe
//   i_inflight : granted requests still awaiting a response
//   i_drop_cnt : responses still to be discarded after a redirect
// -----------------------------------------------------------------------------
module if_fetch_unit_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          i_rvalid,
    input logic [CW-1:0] i_inflight,
    input logic [CW-1:0] i_drop_cnt
);

    // A response with nothing outstanding means the memory broke ordering.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        i_rvalid |-> (i_inflight != '0));

    // Outstanding requests and pending discards stay within the queue depth.
    a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
        (i_inflight <= CW'(DEPTH)) && (i_drop_cnt <= i_inflight));

endmodule

// File: rtl/if_fetch_unit_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_fetch_queue
// DEPTH-entry in-order ring buffer of fetch slots. A slot is reserved (PC tag
// written) when its request is granted, filled when its data returns, and
// released when the head is popped. Three pointers walk the ring:
// reserve >= fill >= head (modulo DEPTH).
//   clk, rst      : clock, asynchronous active-high reset
//   i_flush       : drop every slot, reserved or filled
//   i_reserve     : reserve next free slot, tagged with i_reserve_pc
//   i_fill        : write i_fill_data into oldest reserved-unfilled slot
//   i_pop         : release the head slot
//   o_head        : head slot contents
//   o_count       : number of reserved slots (filled and unfilled)
// -----------------------------------------------------------------------------
module if_fetch_unit_fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_reserve,
    input  InstAddrBus   i_reserve_pc,
    input  logic         i_fill,
    input  InstBus       i_fill_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count
);

    fetch_entry_t    r_entries [DEPTH];
    logic [AW-1:0]   r_res_ptr;
    logic [AW-1:0]   r_fill_ptr;
    logic [AW-1:0]   r_head_ptr;
    logic [CW-1:0]   r_count;

    // Slot storage, ring pointers and occupancy. Reserve, fill and pop never
    // touch the same slot in one cycle: the reserve slot is free, the fill slot
    // is reserved-unfilled and the pop slot is filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= EMPTY_ENTRY;
            end
            r_res_ptr  <= '0;
            r_fill_ptr <= '0;
            r_head_ptr <= '0;
            r_count    <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= EMPTY_ENTRY;
            end
            r_res_ptr  <= '0;
            r_fill_ptr <= '0;
            r_head_ptr <= '0;
            r_count    <= '0;
        end else begin
            if (i_reserve) begin
                r_entries[r_res_ptr].pc     <= i_reserve_pc;
                r_entries[r_res_ptr].inst   <= INST_NOP;
                r_entries[r_res_ptr].filled <= 1'b0;
                r_res_ptr                   <= r_res_ptr + AW'(1);
            end
            if (i_fill) begin
                r_entries[r_fill_ptr].inst   <= i_fill_data;
                r_entries[r_fill_ptr].filled <= 1'b1;
                r_fill_ptr                   <= r_fill_ptr + AW'(1);
            end
            if (i_pop) begin
                r_entries[r_head_ptr].filled <= 1'b0;
                r_entries[r_head_ptr].inst   <= INST_NOP;
                r_head_ptr                   <= r_head_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_reserve) - CW'(i_pop);
        end
    end

    // Head slot and occupancy straight from registers.
    always_comb begin
        o_head  = r_entries[r_head_ptr];
        o_count = r_count;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the fetch PC, issues word fetches with up to
// DEPTH requests in flight, buffers returned words with their PCs in an
// in-order queue and presents the queue head to decode.
//   clk, rst       : clock, asynchronous active-high reset
//   redirect_i     : flush and restart fetch at redirect_pc_i
//   redirect_pc_i  : redirect target (byte offset bits ignored)
//   hold_i         : decode stall, head is not consumed
//   imem           : instruction memory bus (master side)
//   inst_valid_o   : head slot holds a returned instruction
//   pc_o           : head slot PC, or the fetch PC when the queue is empty
//   inst_o         : head instruction, INST_NOP when not valid
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter InstAddrBus RESET_PC = 32'h0000_0000,
    parameter int         DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  InstAddrBus            redirect_pc_i,
    input  logic                  hold_i,
    if_fetch_unit_if.master       imem,
    output logic                  inst_valid_o,
    output InstAddrBus            pc_o,
    output InstBus                inst_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    InstAddrBus      r_fetch_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_inflight_next;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;
    logic            w_req;
    logic            w_grant;
    logic            w_drop;
    logic            w_fill;
    logic            w_pop;

    // Request/response decode. Requests are also capped by the in-flight
    // count so that discarded responses from before a redirect plus new
    // requests never exceed DEPTH outstanding.
    always_comb begin
        w_req   = !rst && !redirect_i
                  && (w_count < CW'(DEPTH))
                  && (r_inflight < CW'(DEPTH));
        w_grant = w_req && imem.gnt;
        w_drop  = imem.rvalid && (r_drop_cnt != '0);
        // A live response arriving during a redirect is stale: the flush wins.
        w_fill  = imem.rvalid && !w_drop && !redirect_i;
        w_pop   = w_head.filled && !hold_i && !redirect_i;
        w_inflight_next = r_inflight + CW'(w_grant) - CW'(imem.rvalid);
    end

    // Fetch PC: redirect target, else advance one word per grant (wraps at 2^32).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= word_align(RESET_PC);
        end else if (redirect_i) begin
            r_fetch_pc <= word_align(redirect_pc_i);
        end else if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end else begin
            r_fetch_pc <= r_fetch_pc;
        end
    end

    // Outstanding request count, net of same-cycle grant and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= w_inflight_next;
        end
    end

    // Responses to discard. On a redirect every response still outstanding
    // after this cycle belongs to the flushed path, so the discard count
    // becomes the next in-flight count (this already nets out a discard or
    // a live response consumed in the redirect cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (redirect_i) begin
            r_drop_cnt <= w_inflight_next;
        end else if (w_drop) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    if_fetch_unit_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (redirect_i),
        .i_reserve    (w_grant),
        .i_reserve_pc (word_align(r_fetch_pc)),
        .i_fill       (w_fill),
        .i_fill_data  (imem.rdata),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    if_fetch_unit_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .i_rvalid   (imem.rvalid),
        .i_inflight (r_inflight),
        .i_drop_cnt (r_drop_cnt)
    );

    // Bus and decode-facing outputs; all but req come straight from registers.
    always_comb begin
        imem.req     = w_req;
        imem.addr    = word_align(r_fetch_pc);
        inst_valid_o = w_head.filled;
        inst_o       = w_head.filled ? w_head.inst : INST_NOP;
        pc_o         = (w_count != '0) ? w_head.pc : r_fetch_pc;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       redirect_i = 1'b0;
    InstAddrBus redirect_pc_i = 32'h0000_0000;
    logic       hold_i = 1'b0;
    logic       inst_valid_o;
    InstAddrBus pc_o;
    InstBus     inst_o;

    if_fetch_unit_if imem ();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .hold_i        (hold_i),
        .imem          (imem),
        .inst_valid_o  (inst_valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        InstAddrBus pc;
        InstBus     inst;
    } exp_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       exp_q[$];
    InstAddrBus pend_q[$];
    int         gnt_budget = 0;
    bit         gnt_block  = 1'b0;
    bit         rv_block   = 1'b0;
    InstAddrBus exp_addr   = 32'h0000_0000;
    int         n_grants   = 0;

    // memory contents: each word is its address xor a fixed pattern
    function automatic InstBus mem_word(input InstAddrBus a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input InstAddrBus pc, input InstBus inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input InstAddrBus base, input int n);
        for (int i = 0; i < n; i++) begin
            push_exp(base + 32'(4 * i), mem_word(base + 32'(4 * i)));
        end
    endtask

    task automatic do_redirect(input InstAddrBus pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        exp_addr      = {pc[31:2], 2'b00};
        n_grants      = 0;
        tick(1);
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0000_0000;
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check32(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // memory model, edge side: retire presented response, record grants
    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
        end else begin
            if (imem.rvalid) void'(pend_q.pop_front());
            if (imem.req && imem.gnt) begin
                check32("grant_addr", imem.addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
                pend_q.push_back(imem.addr);
                gnt_budget--;
                n_grants++;
            end
        end
    end

    // memory model, drive side: grant and respond for the coming edge
    always @(negedge clk) begin
        imem.gnt = !rst && imem.req && !gnt_block && (gnt_budget > 0);
        if (!rst && !rv_block && (pend_q.size() > 0)) begin
            imem.rvalid = 1'b1;
            imem.rdata  = mem_word(pend_q[0]);
        end else begin
            imem.rvalid = 1'b0;
            imem.rdata  = 32'h0000_0000;
        end
    end

    // scoreboard monitor: every consumed head must match the next expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && inst_valid_o && !hold_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h inst %h, expected no instruction", pc_o, inst_o);
            end else begin
                e = exp_q.pop_front();
                check32("pop_pc", pc_o, e.pc);
                check32("pop_inst", inst_o, e.inst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0000_0000;

        // reset values
        tick(3);
        check32("rst_req", 32'(imem.req), 32'd0);
        check32("rst_valid", 32'(inst_valid_o), 32'd0);
        check32("rst_inst", inst_o, 32'h0000_0013);
        check32("rst_pc", pc_o, 32'h0000_0000);

        // 1: free-running from reset, first valid two cycles after release
        gnt_budget = 8;
        exp_addr   = 32'h0000_0000;
        push_seq(32'h0000_0000, 8);
        rst = 1'b0;
        tick(1);
        check32("t1_valid_c2", 32'(inst_valid_o), 32'd0);
        tick(1);
        check32("t1_valid_c3", 32'(inst_valid_o), 32'd1);
        check32("t1_pc_c3", pc_o, 32'h0000_0000);
        check32("t1_inst_c3", inst_o, 32'hC0DE_0000);
        wait_drain("t1_drain", 100);

        // 2: hold fills the queue, exactly DEPTH grants
        hold_i     = 1'b1;
        gnt_budget = 8;
        do_redirect(32'h0000_0000);
        tick(10);
        check32("t2_grants", 32'(n_grants), 32'd4);
        check32("t2_req_full", 32'(imem.req), 32'd0);
        check32("t2_head_pc", pc_o, 32'h0000_0000);
        check32("t2_head_inst", inst_o, 32'hC0DE_0000);
        push_seq(32'h0000_0000, 8);
        hold_i = 1'b0;
        #1;
        check32("t2_req_full_pop", 32'(imem.req), 32'd0);
        wait_drain("t2_drain", 100);

        // 3: three requests in flight, redirect to 0x100
        rv_block   = 1'b1;
        n_grants   = 0;
        gnt_budget = 3;
        tick(5);
        check32("t3_grants", 32'(n_grants), 32'd3);
        check32("t3_valid_wait", 32'(inst_valid_o), 32'd0);
        push_exp(32'h0000_0100, 32'hC0DE_0100);
        push_exp(32'h0000_0104, 32'hC0DE_0104);
        push_exp(32'h0000_0108, 32'hC0DE_0108);
        push_exp(32'h0000_010C, 32'hC0DE_010C);
        gnt_budget = 4;
        do_redirect(32'h0000_0100);
        rv_block = 1'b0;
        check32("t3_valid_after", 32'(inst_valid_o), 32'd0);
        wait_drain("t3_drain", 100);

        // 4: redirect in a cycle carrying a live response
        gnt_budget = 3;
        push_exp(32'h0000_0110, 32'hC0DE_0110);
        tick(3);
        check32("t4_q_before", 32'(exp_q.size()), 32'd0);
        push_exp(32'h0000_0200, 32'hC0DE_0200);
        push_exp(32'h0000_0204, 32'hC0DE_0204);
        push_exp(32'h0000_0208, 32'hC0DE_0208);
        push_exp(32'h0000_020C, 32'hC0DE_020C);
        gnt_budget = 4;
        do_redirect(32'h0000_0202);
        check32("t4_valid_after", 32'(inst_valid_o), 32'd0);
        wait_drain("t4_drain", 100);

        // 5a: grant delayed, address held
        gnt_block  = 1'b1;
        gnt_budget = 2;
        push_exp(32'h0000_0210, 32'hC0DE_0210);
        push_exp(32'h0000_0214, 32'hC0DE_0214);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check32("t5_req_held", 32'(imem.req), 32'd1);
            check32("t5_addr_held", imem.addr, 32'h0000_0210);
        end
        gnt_block = 1'b0;
        wait_drain("t5_drain", 100);

        // 5b: reset mid-burst
        hold_i     = 1'b1;
        gnt_budget = 10;
        tick(2);
        rst = 1'b1;
        #1;
        check32("t5_rst_req", 32'(imem.req), 32'd0);
        check32("t5_rst_valid", 32'(inst_valid_o), 32'd0);
        check32("t5_rst_inst", inst_o, 32'h0000_0013);
        check32("t5_rst_pc", pc_o, 32'h0000_0000);
        gnt_budget = 0;
        tick(2);
        exp_addr   = 32'h0000_0000;
        gnt_budget = 2;
        push_exp(32'h0000_0000, 32'hC0DE_0000);
        push_exp(32'h0000_0004, 32'hC0DE_0004);
        hold_i = 1'b0;
        rst    = 1'b0;
        wait_drain("t5_rst_drain", 100);

        // 6: address wrap
        push_exp(32'hFFFF_FFF8, 32'h3F21_FFF8);
        push_exp(32'hFFFF_FFFC, 32'h3F21_FFFC);
        push_exp(32'h0000_0000, 32'hC0DE_0000);
        gnt_budget = 3;
        do_redirect(32'hFFFF_FFF8);
        wait_drain("t6_drain", 100);
        tick(2);
        check32("t6_fetch_pc", pc_o, 32'h0000_0004);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
